// File: rtl/traffic_lock_pkg.sv
// Shared state types and width helper for the traffic light / sequence lock controller.
package traffic_lock_pkg;

    typedef enum logic [1:0] {TL_RED, TL_GREEN, TL_YELLOW} traffic_state_t;
    typedef enum logic [1:0] {LK_IDLE, LK_ENTRY, LK_OPEN, LK_LOCKOUT} lock_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_press_detect.sv
// Rising-edge detector for a key bus: flags a press, its lowest rising index,
// and whether more than one bit rose in the same cycle.
module key_press_detect
    import traffic_lock_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [W-1:0]             level,
    output logic                     press_valid,
    output logic [width_of(W)-1:0]   press_idx,
    output logic                     multi
);

    localparam int IW = width_of(W);

    logic [W-1:0] history;
    logic [W-1:0] rose;

    always_ff @(posedge clock) begin
        if (reset) history <= '0;
        else       history <= level;
    end

    assign rose        = level & ~history;
    assign press_valid = |rose;
    // Clearing the lowest set bit leaves something only if two or more bits rose.
    assign multi       = |(rose & (rose - 1'b1));

    always_comb begin
        press_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (rose[i]) press_idx = IW'(i);
        end
    end

endmodule

// File: rtl/traffic_lock_controller.sv
// Tick-driven traffic light FSM plus programmable N-key sequence lock with relock and lockout.
// Optional pedestrian cut-short of GREEN is built when PED_REQUEST_EN is defined.
module traffic_lock_controller
    import traffic_lock_pkg::*;
#(
    parameter int KEY_W         = 4,
    parameter int SEQ_LEN       = 4,
    parameter int T_RED         = 3,
    parameter int T_GREEN       = 3,
    parameter int T_YELLOW      = 1,
    parameter int OPEN_TICKS    = 4,
    parameter int MAX_ERRORS    = 3,
    parameter int LOCKOUT_TICKS = 5,
    parameter int T_MIN_GREEN   = 1,
    localparam int IDX_W = width_of(KEY_W),
    localparam int PW    = width_of(SEQ_LEN + 1),
    localparam int EW    = width_of(MAX_ERRORS + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     tick,
    input  logic [KEY_W-1:0]         key,
    input  logic [SEQ_LEN*IDX_W-1:0] code,
    input  logic                     ped_req,
    output logic                     lamp_red,
    output logic                     lamp_yellow,
    output logic                     lamp_green,
    output logic                     lock_open,
    output logic                     lock_lockout,
    output logic [PW-1:0]            lock_progress,
    output logic [EW-1:0]            err_count
);

    localparam int T_MAX  = (T_RED > T_GREEN) ? ((T_RED > T_YELLOW) ? T_RED : T_YELLOW)
                                              : ((T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW);
    localparam int TW     = width_of(T_MAX);
    localparam int LT_MAX = (OPEN_TICKS > LOCKOUT_TICKS) ? OPEN_TICKS : LOCKOUT_TICKS;
    localparam int LW     = width_of(LT_MAX);

    if (KEY_W < 2 || KEY_W > 8)                  begin : g_bad_key_w   $error("KEY_W out of range");       end
    if (SEQ_LEN < 1 || SEQ_LEN > 8)              begin : g_bad_seq_len $error("SEQ_LEN out of range");     end
    if (T_RED < 1 || T_GREEN < 1 || T_YELLOW < 1) begin : g_bad_phase  $error("phase length must be >=1"); end
    if (OPEN_TICKS < 1 || LOCKOUT_TICKS < 1)     begin : g_bad_lk_time $error("lock timers must be >=1");  end
    if (MAX_ERRORS < 1)                          begin : g_bad_max_err $error("MAX_ERRORS must be >=1");   end
    if (T_MIN_GREEN < 1 || T_MIN_GREEN > T_GREEN) begin : g_bad_min_g  $error("T_MIN_GREEN out of range"); end

    traffic_state_t traffic_state;
    logic [TW-1:0]  phase_timer;
    lock_state_t    lock_state;
    logic [LW-1:0]  lock_timer;

    logic             press_valid;
    logic [IDX_W-1:0] press_idx;
    logic             multi;
    logic [IDX_W-1:0] slot;
    logic             slot_match;
    logic             ped_cut;

    key_press_detect #(.W(KEY_W)) u_key_detect (
        .clock       (clock),
        .reset       (reset),
        .level       (key),
        .press_valid (press_valid),
        .press_idx   (press_idx),
        .multi       (multi)
    );

`ifdef PED_REQUEST_EN
    logic ped_rise;
    logic unused_ped_idx;
    logic unused_ped_multi;
    logic ped_pending;
    logic enter_yellow;

    key_press_detect #(.W(1)) u_ped_detect (
        .clock       (clock),
        .reset       (reset),
        .level       (ped_req),
        .press_valid (ped_rise),
        .press_idx   (unused_ped_idx),
        .multi       (unused_ped_multi)
    );

    assign ped_cut      = ped_pending && (phase_timer >= TW'(T_MIN_GREEN - 1));
    assign enter_yellow = (traffic_state == TL_GREEN) && tick &&
                          ((phase_timer == TW'(T_GREEN - 1)) || ped_cut);

    // A new request in the same cycle GREEN ends is kept for the next GREEN.
    always_ff @(posedge clock) begin
        if (reset)             ped_pending <= 1'b0;
        else if (ped_rise)     ped_pending <= 1'b1;
        else if (enter_yellow) ped_pending <= 1'b0;
    end
`else
    logic unused_ped;
    assign unused_ped = ped_req;
    assign ped_cut    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            traffic_state <= TL_RED;
            phase_timer   <= '0;
        end else begin
            case (traffic_state)
                TL_RED: if (tick) begin
                    if (phase_timer == TW'(T_RED - 1)) begin
                        traffic_state <= TL_GREEN;
                        phase_timer   <= '0;
                    end else phase_timer <= phase_timer + 1'b1;
                end
                TL_GREEN: if (tick) begin
                    if (phase_timer == TW'(T_GREEN - 1) || ped_cut) begin
                        traffic_state <= TL_YELLOW;
                        phase_timer   <= '0;
                    end else phase_timer <= phase_timer + 1'b1;
                end
                TL_YELLOW: if (tick) begin
                    if (phase_timer == TW'(T_YELLOW - 1)) begin
                        traffic_state <= TL_RED;
                        phase_timer   <= '0;
                    end else phase_timer <= phase_timer + 1'b1;
                end
                default: begin
                    traffic_state <= TL_RED;
                    phase_timer   <= '0;
                end
            endcase
        end
    end

    // Unused encodings light red so exactly one lamp is always on.
    assign lamp_green  = (traffic_state == TL_GREEN);
    assign lamp_yellow = (traffic_state == TL_YELLOW);
    assign lamp_red    = !(lamp_green || lamp_yellow);

    assign slot       = code[int'(lock_progress) * IDX_W +: IDX_W];
    assign slot_match = !multi && (int'(slot) < KEY_W) && (slot == press_idx);

    always_ff @(posedge clock) begin
        if (reset) begin
            lock_state    <= LK_IDLE;
            lock_progress <= '0;
            err_count     <= '0;
            lock_timer    <= '0;
        end else begin
            case (lock_state)
                LK_IDLE, LK_ENTRY: if (press_valid) begin
                    if (slot_match) begin
                        if (lock_progress == PW'(SEQ_LEN - 1)) begin
                            lock_state    <= LK_OPEN;
                            lock_progress <= '0;
                            err_count     <= '0;
                            lock_timer    <= '0;
                        end else begin
                            lock_state    <= LK_ENTRY;
                            lock_progress <= lock_progress + 1'b1;
                        end
                    end else begin
                        lock_progress <= '0;
                        err_count     <= err_count + 1'b1;
                        if (err_count == EW'(MAX_ERRORS - 1)) begin
                            lock_state <= LK_LOCKOUT;
                            lock_timer <= '0;
                        end else lock_state <= LK_IDLE;
                    end
                end
                LK_OPEN: if (tick) begin
                    if (lock_timer == LW'(OPEN_TICKS - 1)) begin
                        lock_state <= LK_IDLE;
                        lock_timer <= '0;
                    end else lock_timer <= lock_timer + 1'b1;
                end
                LK_LOCKOUT: if (tick) begin
                    if (lock_timer == LW'(LOCKOUT_TICKS - 1)) begin
                        lock_state <= LK_IDLE;
                        lock_timer <= '0;
                        err_count  <= '0;
                    end else lock_timer <= lock_timer + 1'b1;
                end
                default: begin
                    lock_state    <= LK_IDLE;
                    lock_progress <= '0;
                    lock_timer    <= '0;
                end
            endcase
        end
    end

    assign lock_open    = (lock_state == LK_OPEN);
    assign lock_lockout = (lock_state == LK_LOCKOUT);

endmodule
